// File: rtl/conv3x3_stream_if.sv
// Stream bundle for conv3x3_stream: pixel input channel and result output channel.
// The engine side uses the slave modport, the pixel source / result sink uses master.
interface conv3x3_stream_if #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
);
  localparam int ROW_W = $clog2(IMG_H - 2) + 1;
  localparam int COL_W = $clog2(IMG_W - 2) + 1;

  logic [WIDTH-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (
    output pix_in, pix_valid, out_ready,
    input  pix_ready, out_data, out_valid, out_row, out_col
  );

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output pix_ready, out_data, out_valid, out_row, out_col
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution over an IMG_H x IMG_W raster image.
// Two line buffers feed a 3x3 window; one result per generating pixel, one cycle later.
// Optional macro CONV3X3_ROUND_EN: round half up before the right shift (default: truncate).
module conv3x3_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int SHIFT = 0,
  parameter int ACC_W = 2 * WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9*WIDTH-1:0]   kernel_in,
  output logic                 busy,
  output logic                 done,
  conv3x3_stream_if.slave      bus
);
  localparam int ROW_W = $clog2(IMG_H - 2) + 1;
  localparam int COL_W = $clog2(IMG_W - 2) + 1;
  localparam int R_W   = $clog2(IMG_H);
  localparam int C_W   = $clog2(IMG_W);
  localparam logic [ACC_W-1:0] PIX_MAX = {{(ACC_W - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [R_W-1:0]   r_q;
  logic [C_W-1:0]   c_q;
  logic [WIDTH-1:0] kern_q [3][3];
  logic [WIDTH-1:0] win_q  [3][3];
  logic [WIDTH-1:0] win_d  [3][3];
  logic [WIDTH-1:0] lb0_q  [IMG_W];
  logic [WIDTH-1:0] lb1_q  [IMG_W];
  logic             accept, gen, last_pix, out_fire;
  logic [ACC_W-1:0] sum, res;
  logic [WIDTH-1:0] sat;

  assign bus.pix_ready = (state_q == RUN) && !(bus.out_valid && !bus.out_ready);
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign last_pix      = (r_q == R_W'(IMG_H - 1)) && (c_q == C_W'(IMG_W - 1));
  assign gen           = accept && (r_q >= R_W'(2)) && (c_q >= C_W'(2));
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign busy          = (state_q != IDLE);

  // Next-state logic: a frame runs until the last pixel, then drains its final result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = FLUSH;
      FLUSH:   if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and the done pulse that follows acceptance of the final result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FLUSH) && out_fire;
    end
  end

  // Window after the pending shift: old columns move left, line buffers and new pixel fill the right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_d[i][0] = win_q[i][1];
      win_d[i][1] = win_q[i][2];
    end
    win_d[0][2] = lb0_q[c_q];
    win_d[1][2] = lb1_q[c_q];
    win_d[2][2] = bus.pix_in;
  end

  // Multiply-accumulate of the shifted window against the latched kernel.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum = sum + ACC_W'(win_d[i][j]) * ACC_W'(kern_q[i][j]);
      end
    end
  end

`ifdef CONV3X3_ROUND_EN
  localparam logic [ACC_W:0] RND_ADD =
    (SHIFT > 0) ? ((ACC_W + 1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  logic [ACC_W:0] rnd;

  // Round half up using one extra bit so the bias addition cannot wrap.
  always_comb begin
    rnd = {1'b0, sum} + RND_ADD;
    res = ACC_W'(rnd >> SHIFT);
  end
`else
  assign res = sum >> SHIFT;
`endif

  assign sat = (res > PIX_MAX) ? {WIDTH{1'b1}} : res[WIDTH-1:0];

  // Kernel latch at frame start and raster position counters advanced per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) kern_q[i][j] <= '0;
      end
    end else if ((state_q == IDLE) && start) begin
      r_q <= '0;
      c_q <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) kern_q[i][j] <= kernel_in[(3 * i + j) * WIDTH +: WIDTH];
      end
    end else if (accept) begin
      if (c_q == C_W'(IMG_W - 1)) begin
        c_q <= '0;
        r_q <= last_pix ? '0 : r_q + R_W'(1);
      end else begin
        c_q <= c_q + C_W'(1);
      end
    end
  end

  // Window and line buffers: lb1 holds row r-1, lb0 holds row r-2 at each column.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      end
      for (int k = 0; k < IMG_W; k++) begin
        lb0_q[k] <= '0;
        lb1_q[k] <= '0;
      end
    end else if (accept) begin
      win_q      <= win_d;
      lb0_q[c_q] <= lb1_q[c_q];
      lb1_q[c_q] <= bus.pix_in;
    end
  end

  // Output register: loads on a generating pixel, holds under backpressure, clears valid on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
    end else if (gen) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sat;
      bus.out_row   <= ROW_W'(r_q - R_W'(2));
      bus.out_col   <= COL_W'(c_q - C_W'(2));
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
